// File: rtl/ddr2_read_return_checker.sv
// Read-return checker for the DDR2 controller: matches returned bursts against
// queued expectations, checks address sequencing, and emits completion records.
module ddr2_read_return_checker #(
  parameter int EXP_DEPTH = 8,
  parameter int CPL_DEPTH = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        exp_valid_i,
  output logic        exp_ready_o,
  input  logic [24:0] exp_addr_i,
  input  logic [1:0]  exp_sz_i,
  input  logic        validout_i,
  input  logic [15:0] dout_i,
  input  logic [24:0] raddr_i,
  output logic        cpl_valid_o,
  input  logic        cpl_ready_i,
  output logic [24:0] cpl_addr_o,
  output logic [5:0]  cpl_len_o,
  output logic [15:0] cpl_xor_o,
  output logic [1:0]  cpl_status_o,
  output logic        err_unexpected_o,
  output logic        err_cpl_drop_o,
  input  logic        err_clear_i,
  output logic        busy_o
);
  localparam int EAW = $clog2(EXP_DEPTH);
  localparam int CAW = $clog2(CPL_DEPTH);
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic [24:0] addr;
    logic [1:0]  sz;
  } exp_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [5:0]  len;
    logic [15:0] x;
    logic [1:0]  st;
  } cpl_t;

  typedef enum logic {IDLE, BURST} state_t;

  exp_t   exp_mem [EXP_DEPTH];
  cpl_t   cpl_mem [CPL_DEPTH];
  logic [EAW:0] ewp_q, erp_q;
  logic [CAW:0] cwp_q, crp_q;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [TW-1:0] to_q, to_d;
  logic [15:0] xor_q, xor_d;
  logic        mm_q, mm_d;
  logic        unexp_q, drop_q;

  exp_t  head;
  cpl_t  cpl_head, cpl_wdata;
  logic  exp_empty, exp_full, exp_push, exp_pop;
  logic  cpl_empty, cpl_full, cpl_wr, cpl_pop, cpl_push, cpl_drop;
  logic  unexp_ev, beat_mm;
  logic [5:0]  blen, idx_inc;
  logic [15:0] xor_n;
  logic        mm_n;

  assign exp_empty   = (ewp_q == erp_q);
  assign exp_full    = (ewp_q[EAW] != erp_q[EAW]) && (ewp_q[EAW-1:0] == erp_q[EAW-1:0]);
  assign exp_ready_o = !exp_full;
  assign exp_push    = exp_valid_i && !exp_full;
  assign head        = exp_mem[erp_q[EAW-1:0]];
  assign blen        = {({1'b0, head.sz} + 3'd1), 3'b000};
  assign idx_inc     = idx_q + 6'd1;
  // idx is held at 0 in IDLE, so this also checks the first beat of a burst.
  assign beat_mm     = (raddr_i != (head.addr + {19'b0, idx_q}));
  assign xor_n       = xor_q ^ dout_i;
  assign mm_n        = mm_q | beat_mm;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    to_d      = to_q;
    xor_d     = xor_q;
    mm_d      = mm_q;
    exp_pop   = 1'b0;
    cpl_wr    = 1'b0;
    cpl_wdata = '0;
    unexp_ev  = 1'b0;
    case (state_q)
      IDLE: begin
        if (validout_i) begin
          if (!exp_empty) begin
            state_d = BURST;
            xor_d   = dout_i;
            idx_d   = 6'd1;
            to_d    = '0;
            mm_d    = beat_mm;
          end else begin
            unexp_ev = 1'b1;
          end
        end
      end
      BURST: begin
        if (validout_i) begin
          to_d = '0;
          if (idx_inc == blen) begin
            cpl_wr    = 1'b1;
            cpl_wdata = '{addr: head.addr, len: blen, x: xor_n, st: {1'b0, mm_n}};
            exp_pop   = 1'b1;
            state_d   = IDLE;
            idx_d     = '0;
            xor_d     = '0;
            mm_d      = 1'b0;
          end else begin
            idx_d = idx_inc;
            xor_d = xor_n;
            mm_d  = mm_n;
          end
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          cpl_wr    = 1'b1;
          cpl_wdata = '{addr: head.addr, len: idx_q, x: xor_q, st: {1'b1, mm_q}};
          exp_pop   = 1'b1;
          state_d   = IDLE;
          idx_d     = '0;
          xor_d     = '0;
          mm_d      = 1'b0;
          to_d      = '0;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full completion FIFO still accepts the record if its head leaves this cycle.
  assign cpl_empty = (cwp_q == crp_q);
  assign cpl_full  = (cwp_q[CAW] != crp_q[CAW]) && (cwp_q[CAW-1:0] == crp_q[CAW-1:0]);
  assign cpl_pop   = !cpl_empty && cpl_ready_i;
  assign cpl_push  = cpl_wr && (!cpl_full || cpl_pop);
  assign cpl_drop  = cpl_wr && cpl_full && !cpl_pop;
  assign cpl_head  = cpl_empty ? '0 : cpl_mem[crp_q[CAW-1:0]];

  always_ff @(posedge clk_i) begin
    if (exp_push) exp_mem[ewp_q[EAW-1:0]] <= '{addr: exp_addr_i, sz: exp_sz_i};
    if (cpl_push) cpl_mem[cwp_q[CAW-1:0]] <= cpl_wdata;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      to_q    <= '0;
      xor_q   <= '0;
      mm_q    <= 1'b0;
      ewp_q   <= '0;
      erp_q   <= '0;
      cwp_q   <= '0;
      crp_q   <= '0;
      unexp_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
      xor_q   <= xor_d;
      mm_q    <= mm_d;
      if (exp_push) ewp_q <= ewp_q + 1'b1;
      if (exp_pop)  erp_q <= erp_q + 1'b1;
      if (cpl_push) cwp_q <= cwp_q + 1'b1;
      if (cpl_pop)  crp_q <= crp_q + 1'b1;
      unexp_q <= (unexp_q && !err_clear_i) || unexp_ev;
      drop_q  <= (drop_q && !err_clear_i) || cpl_drop;
    end
  end

  assign cpl_valid_o      = !cpl_empty;
  assign cpl_addr_o       = cpl_head.addr;
  assign cpl_len_o        = cpl_head.len;
  assign cpl_xor_o        = cpl_head.x;
  assign cpl_status_o     = cpl_head.st;
  assign err_unexpected_o = unexp_q;
  assign err_cpl_drop_o   = drop_q;
  assign busy_o           = (state_q == BURST);
endmodule

// File: tb/tb_ddr2_read_return_checker.sv
// Bench for ddr2_read_return_checker: directed vector table, hand-written corner
// sequences, and randomized bursts against a per-burst reference model.
module tb_ddr2_read_return_checker;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        exp_valid_i = 1'b0, exp_ready_o;
  logic [24:0] exp_addr_i = '0;
  logic [1:0]  exp_sz_i = '0;
  logic        validout_i = 1'b0;
  logic [15:0] dout_i = '0;
  logic [24:0] raddr_i = '0;
  logic        cpl_valid_o, cpl_ready_i = 1'b1;
  logic [24:0] cpl_addr_o;
  logic [5:0]  cpl_len_o;
  logic [15:0] cpl_xor_o;
  logic [1:0]  cpl_status_o;
  logic        err_unexpected_o, err_cpl_drop_o, err_clear_i = 1'b0, busy_o;

  ddr2_read_return_checker #(.EXP_DEPTH(8), .CPL_DEPTH(4), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .exp_valid_i(exp_valid_i), .exp_ready_o(exp_ready_o),
    .exp_addr_i(exp_addr_i), .exp_sz_i(exp_sz_i),
    .validout_i(validout_i), .dout_i(dout_i), .raddr_i(raddr_i),
    .cpl_valid_o(cpl_valid_o), .cpl_ready_i(cpl_ready_i),
    .cpl_addr_o(cpl_addr_o), .cpl_len_o(cpl_len_o), .cpl_xor_o(cpl_xor_o),
    .cpl_status_o(cpl_status_o),
    .err_unexpected_o(err_unexpected_o), .err_cpl_drop_o(err_cpl_drop_o),
    .err_clear_i(err_clear_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] addr;
    logic [5:0]  len;
    logic [15:0] x;
    logic [1:0]  st;
  } rec_t;

  typedef struct {
    logic [24:0] addr;
    logic [1:0]  sz;
    int          nb;
    int          bad;
    logic [5:0]  elen;
    logic [15:0] ex;
    logic [1:0]  est;
  } vec_t;

  int   nvec = 0, nmis = 0, cyc = 0;
  rec_t got_q[$];
  int   got_cyc[$];
  rec_t exp_q[$];
  bit   rnd_done;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer-side monitor: a record is taken whenever valid && ready at the edge.
  always @(negedge clk)
    if (reset_i && cpl_valid_o && cpl_ready_i) begin
      got_q.push_back('{addr: cpl_addr_o, len: cpl_len_o, x: cpl_xor_o, st: cpl_status_o});
      got_cyc.push_back(cyc);
    end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [24:0] a, input logic [1:0] sz);
    int k = 0;
    while (!exp_ready_o && k < 100) begin tick(); k++; end
    chk("exp_ready_wait", exp_ready_o, 1);
    exp_valid_i = 1'b1; exp_addr_i = a; exp_sz_i = sz;
    tick();
    exp_valid_i = 1'b0;
  endtask

  task automatic beat(input logic [24:0] ra, input logic [15:0] d);
    validout_i = 1'b1; raddr_i = ra; dout_i = d;
    tick();
    validout_i = 1'b0;
  endtask

  task automatic wait_rec(input int n, input int lim, input string name);
    int k = 0;
    while (got_q.size() < n && k < lim) begin tick(); k++; end
    chk(name, got_q.size() >= n, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cpl_valid"}, cpl_valid_o, 0);
    chk({tag, "_cpl_fields"}, {cpl_addr_o, cpl_len_o, cpl_xor_o, cpl_status_o}, 0);
    chk({tag, "_errs"}, {err_unexpected_o, err_cpl_drop_o}, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_exp_ready"}, exp_ready_o, 1);
  endtask

  initial begin
    vec_t        vt[5];
    logic [24:0] ra, ba[5];
    logic [15:0] d, x;
    int          n0, k, bad, len;
    bit          trunc;

    vt[0] = '{25'h0000100, 2'd0, 8,  -1, 6'd8,  16'h0008, 2'b00};
    vt[1] = '{25'h1FFFFFC, 2'd0, 8,  -1, 6'd8,  16'h0008, 2'b00};
    vt[2] = '{25'h0000040, 2'd1, 16,  5, 6'd16, 16'h0010, 2'b01};
    vt[3] = '{25'h1FFFFF0, 2'd3, 32, -1, 6'd32, 16'h0020, 2'b00};
    vt[4] = '{25'h0000500, 2'd0, 3,  -1, 6'd3,  16'h0000, 2'b10};

    repeat (3) tick();
    chk_reset_outputs("reset");
    reset_i = 1'b1;
    tick();

    // Directed table: full bursts, address wrap, mismatch, timeout.
    for (int v = 0; v < 5; v++) begin
      n0 = got_q.size();
      push_exp(vt[v].addr, vt[v].sz);
      for (int i = 0; i < vt[v].nb; i++) begin
        ra = vt[v].addr + 25'(i) + ((i == vt[v].bad) ? 25'd1 : 25'd0);
        beat(ra, 16'(i + 1));
      end
      if (vt[v].nb == int'(vt[v].elen) && vt[v].est[1] == 1'b0) begin
        @(negedge clk);
        chk($sformatf("v%0d_latency", v), cpl_valid_o, 1);
        chk($sformatf("v%0d_idle", v), busy_o, 0);
        #1;
      end else begin
        repeat (TO - 1) tick();
        chk($sformatf("v%0d_pre_timeout_busy", v), busy_o, 1);
        chk($sformatf("v%0d_pre_timeout_norec", v), got_q.size(), n0);
        tick();
      end
      wait_rec(n0 + 1, 40, $sformatf("v%0d_record", v));
      if (got_q.size() > n0) begin
        chk($sformatf("v%0d_addr", v), got_q[n0].addr, vt[v].addr);
        chk($sformatf("v%0d_len", v), got_q[n0].len, vt[v].elen);
        chk($sformatf("v%0d_xor", v), got_q[n0].x, vt[v].ex);
        chk($sformatf("v%0d_status", v), got_q[n0].st, vt[v].est);
      end
    end

    // Unexpected beat after the timed-out burst emptied the queue.
    n0 = got_q.size();
    beat(25'h0000123, 16'hAAAA);
    repeat (3) tick();
    chk("unexp_flag", err_unexpected_o, 1);
    chk("unexp_norec", got_q.size(), n0);
    chk("unexp_idle", busy_o, 0);
    err_clear_i = 1'b1; tick(); err_clear_i = 1'b0;
    chk("unexp_cleared", err_unexpected_o, 0);
    err_clear_i = 1'b1; validout_i = 1'b1; raddr_i = 25'h7; tick();
    err_clear_i = 1'b0; validout_i = 1'b0;
    chk("unexp_set_beats_clear", err_unexpected_o, 1);
    err_clear_i = 1'b1; tick(); err_clear_i = 1'b0;
    chk("unexp_cleared2", err_unexpected_o, 0);

    // Backpressure: five back-to-back bursts into a four-deep completion FIFO.
    cpl_ready_i = 1'b0;
    n0 = got_q.size();
    for (int b = 0; b < 5; b++) begin
      ba[b] = 25'h0010000 + 25'(b * 25'h100);
      push_exp(ba[b], 2'd0);
    end
    for (int b = 0; b < 5; b++)
      for (int i = 0; i < 8; i++) beat(ba[b] + 25'(i), 16'(b * 16 + i));
    repeat (2) tick();
    chk("bp_drop_flag", err_cpl_drop_o, 1);
    chk("bp_held_valid", cpl_valid_o, 1);
    chk("bp_no_delivery", got_q.size(), n0);
    cpl_ready_i = 1'b1;
    repeat (8) tick();
    chk("bp_drain_count", got_q.size(), n0 + 4);
    for (int j = 0; j < 4; j++)
      if (got_q.size() > n0 + j) begin
        chk($sformatf("bp_order%0d", j), got_q[n0 + j].addr, ba[j]);
        if (j > 0) chk($sformatf("bp_consec%0d", j), got_cyc[n0 + j] - got_cyc[n0 + j - 1], 1);
      end
    chk("bp_empty_after", cpl_valid_o, 0);
    err_clear_i = 1'b1; tick(); err_clear_i = 1'b0;
    chk("bp_drop_cleared", err_cpl_drop_o, 0);

    // Reset in the middle of a burst discards it completely.
    push_exp(25'h0002222, 2'd0);
    for (int i = 0; i < 4; i++) beat(25'h0002222 + 25'(i), 16'(i + 1));
    reset_i = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) tick();
    reset_i = 1'b1;
    n0 = got_q.size();
    push_exp(25'h0003333, 2'd0);
    for (int i = 0; i < 8; i++) beat(25'h0003333 + 25'(i), 16'h1000 + 16'(i));
    repeat (TO + 6) tick();
    chk("midrst_one_record", got_q.size(), n0 + 1);
    if (got_q.size() > n0) begin
      chk("midrst_addr", got_q[n0].addr, 25'h0003333);
      chk("midrst_len", got_q[n0].len, 8);
      chk("midrst_status", got_q[n0].st, 0);
    end

    // Randomized bursts: the model derives each record from the beats sent.
    n0 = got_q.size();
    rnd_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 40; b++) begin
          ra = 25'($urandom);
          len = 8 * ($urandom_range(0, 3) + 1);
          trunc = ($urandom_range(0, 4) == 0);
          k = trunc ? $urandom_range(1, len - 1) : len;
          bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, k - 1) : -1;
          x = '0;
          push_exp(ra, 2'(len / 8 - 1));
          for (int i = 0; i < k; i++) begin
            if (i > 0) repeat ($urandom_range(0, 2)) tick();
            d = 16'($urandom);
            x ^= d;
            beat(ra + 25'(i) + ((i == bad) ? 25'd1 : 25'd0), d);
          end
          if (trunc) repeat (TO + 2) tick();
          exp_q.push_back('{addr: ra, len: 6'(k), x: x, st: {trunc, bad >= 0}});
        end
        repeat (10) tick();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          cpl_ready_i = ($urandom_range(0, 3) != 0);
          tick();
        end
        cpl_ready_i = 1'b1;
      end
    join
    wait_rec(n0 + exp_q.size(), 50, "rnd_count");
    chk("rnd_no_drop", err_cpl_drop_o, 0);
    for (int j = 0; j < exp_q.size(); j++)
      if (got_q.size() > n0 + j)
        chk($sformatf("rnd_rec%0d", j),
            {got_q[n0 + j].addr, got_q[n0 + j].len, got_q[n0 + j].x, got_q[n0 + j].st},
            {exp_q[j].addr, exp_q[j].len, exp_q[j].x, exp_q[j].st});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/ddr2_read_return_checker.md
Name: ddr2_read_return_checker

Overview:
- Receives the read-return stream from ddr2_controller (DOUT/RADDR/VALIDOUT), the opposite direction from the command path that controller_driver drives.
- Matches each returned burst against an expected-read queue that the command side loads, checks address sequencing and accumulates an XOR signature.
- Pushes one completion record per burst into an output FIFO, which a consumer drains with a valid/ready handshake.
- VALIDOUT cannot be stalled, so the block never back-pressures the controller.

Parameters:
- EXP_DEPTH, 8: depth of the expected-read FIFO, power of 2, ≥2.
- CPL_DEPTH, 4: depth of the completion FIFO, power of 2, ≥2.
- TIMEOUT, 1024: idle cycles allowed between beats inside a burst before the burst is closed with a timeout.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- exp_valid  in  1  expected read offered.
- exp_ready  out  1  expected FIFO not full.
- exp_addr  in  25  expected start word address.
- exp_sz  in  2  burst size code; length = 8*(exp_sz+1) words.
- validout  in  1  return beat valid, from controller VALIDOUT.
- dout  in  16  return data word.
- raddr  in  25  return word address.
- cpl_valid  out  1  completion record available (FIFO head).
- cpl_ready  in  1  consumer accepts record.
- cpl_addr  out  25  burst start address (from the expectation).
- cpl_len  out  6  beats actually received, 1..32.
- cpl_xor  out  16  XOR of all received dout words.
- cpl_status  out  2  [0] address mismatch, [1] timeout.
- err_unexpected  out  1  sticky: beat arrived with no expectation.
- err_cpl_drop  out  1  sticky: completion lost because the completion FIFO was full.
- err_clear  in  1  clears both sticky errors.
- busy  out  1  state is BURST.

Behaviour:
- Reset (reset=0, async):
  - Both FIFOs empty; state IDLE; counters, flags and accumulators cleared.
  - cpl_valid=0, cpl_addr/len/xor/status=0, err_*=0, busy=0, exp_ready=1.
- Expected FIFO:
  - exp_ready = !full. Push on exp_valid && exp_ready.
  - The head is peeked, not popped, while a burst is active; it is popped in the completion cycle.
  - Push and pop in the same cycle are both honoured.
- State IDLE:
  - validout=1 with expected FIFO non-empty: beat is index 0 of the head expectation. Check it, load xor = dout, set idx=1, clear the timeout counter, go to BURST.
  - validout=1 with expected FIFO empty: beat discarded, err_unexpected set, stay in IDLE.
- Beat check: mismatch flag ORs in (raddr != (head.addr + idx) mod 2^25). The 25-bit address wraps, 0x1FFFFFF → 0x0000000.
- State BURST:
  - Each validout beat: xor ^= dout; idx++; timeout counter cleared.
  - Beat that brings idx to len: completion with status {0, mismatch}; pop expectation; go to IDLE.
  - No beat while timeout counter == TIMEOUT-1: completion with cpl_len = idx and status {1, mismatch}; pop expectation; go to IDLE.
  - Otherwise the timeout counter increments.
- Back-to-back bursts: a beat in the cycle right after a completion is handled from IDLE, with no lost beat.
- Completion FIFO:
  - The record is written at the clock edge that accepts the last beat (or hits timeout). cpl_valid rises the next cycle (1-cycle latency).
  - Outputs show the FIFO head; pop on cpl_valid && cpl_ready.
  - If full at the write edge and not popped that same cycle, the record is dropped and err_cpl_drop is set.
  - If full but popped in the same cycle, the write succeeds.
- Sticky errors: cleared by err_clear=1. A new error event in the same cycle as err_clear wins (flag stays 1).
- Reset mid-burst: everything is discarded immediately; nothing is emitted for the partial burst.
- busy = (state == BURST).

Test Plan:
1. Basic burst:
   - Stimulus: push exp addr=0x0000100 sz=0; 8 consecutive beats with raddr 0x100..0x107 and dout 0x0001..0x0008.
   - Required: exactly one record, addr=0x100, len=8, xor=0x0008, status=0, delivered 1 cycle after the last beat.
2. Address wrap:
   - Stimulus: exp addr=0x1FFFFFC sz=0; raddr 0x1FFFFFC..0x1FFFFFF then 0x0000000..0x0000003.
   - Required: status=0, len=8.
3. Address mismatch:
   - Stimulus: exp sz=1 addr=0x40; beat 5 carries raddr 0x46 instead of 0x45, all others correct.
   - Required: len=16, status=2'b01.
4. Timeout and unexpected beat (TIMEOUT=16):
   - Stimulus: exp sz=0; 3 beats, then silence for 16 cycles.
   - Required: record with len=3, status=2'b10; expected FIFO empty afterwards.
   - Stimulus: a further beat.
   - Required: err_unexpected=1 and no record; err_clear pulse returns it to 0.
5. Backpressure (CPL_DEPTH=4):
   - Stimulus: cpl_ready=0; 5 expectations, 5 bursts of 8 beats (sz=0).
   - Required: 4 records held, 5th dropped, err_cpl_drop=1.
   - Stimulus: cpl_ready=1.
   - Required: 4 records drain in issue order on consecutive cycles.
6. Reset mid-burst:
   - Stimulus: assert reset after 4 beats of an sz=0 burst, then release; new exp sz=0 with 8 beats.
   - Required: all outputs 0 during reset; exactly one record afterwards, for the new burst only.
